// File: rtl/spi_master_ctrl_pkg.sv
// Shared definitions for the SPI master controller: FSM state encoding,
// parameter defaults and counter widths.
package spi_master_ctrl_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_CLK_DIV = 4;
  localparam int DIV_CNT_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_TRAIL = 3'd3,
    ST_DONE  = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Host handshake and SPI pin bundle for spi_master_ctrl.
interface spi_master_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic              SPI_SCK;
  logic              SPI_MOSI;
  logic              SPI_MISO;
  logic              SPI_SS;

  modport master (
    input  start, tx_data, SPI_MISO,
    output busy, done, rx_data, SPI_SCK, SPI_MOSI, SPI_SS
  );

  modport slave (
    output start, tx_data, SPI_MISO,
    input  busy, done, rx_data, SPI_SCK, SPI_MOSI, SPI_SS
  );
endinterface

// File: rtl/spi_sck_gen.sv
// SPI clock divider: while enabled, toggles sck every CLK_DIV clk cycles and
// flags which edge the coming clk edge produces; held low when disabled.
module spi_sck_gen
  import spi_master_ctrl_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(CLK_DIV - 1);

  logic [DIV_CNT_W-1:0] r_div_cnt;
  logic                 r_sck;
  logic                 w_wrap;

  assign w_wrap = en && (r_div_cnt == DIV_LAST);

  // divider counter and SCK flop; counter wraps on every toggle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_sck     <= 1'b0;
    end else if (!en) begin
      r_div_cnt <= '0;
      r_sck     <= 1'b0;
    end else if (w_wrap) begin
      r_div_cnt <= '0;
      r_sck     <= ~r_sck;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_CNT_W'(1);
    end
  end

  assign sck        = r_sck;
  assign rise_pulse = w_wrap & ~r_sck;
  assign fall_pulse = w_wrap & r_sck;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master (CPOL=0, MSB first): frame FSM, bit counter and shift registers;
// SCK comes from spi_sck_gen, which runs only in SHIFT.
module spi_master_ctrl
  import spi_master_ctrl_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input logic               clk,
  input logic               rst,
  spi_master_ctrl_if.master bus
);

  localparam int                   BIT_W    = $clog2(DATA_W + 1);
  localparam logic [BIT_W-1:0]     BIT_LAST = BIT_W'(DATA_W);
  localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(CLK_DIV - 1);

  spi_state_e           r_state;
  spi_state_e           w_state_nxt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [DIV_CNT_W-1:0] r_wait_cnt;
  logic [DATA_W-1:0]    r_tx_sh;
  logic [DATA_W-1:0]    r_rx_sh;
  logic [DATA_W-1:0]    r_rx_data;
  logic                 r_ss;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_sck_en;
  logic                 w_sck;
  logic                 w_rise;
  logic                 w_fall;
  logic                 w_wait_end;

  assign w_sck_en   = (r_state == ST_SHIFT);
  assign w_wait_end = (r_wait_cnt == DIV_LAST);

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk        (clk),
    .rst        (rst),
    .en         (w_sck_en),
    .sck        (w_sck),
    .rise_pulse (w_rise),
    .fall_pulse (w_fall)
  );

  // next-state logic; SHIFT ends on the fall that follows the last rise
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_state_nxt = ST_LEAD;  else w_state_nxt = ST_IDLE;
      ST_LEAD:  if (w_wait_end) w_state_nxt = ST_SHIFT; else w_state_nxt = ST_LEAD;
      ST_SHIFT: begin
        if (w_fall && (r_bit_cnt == BIT_LAST)) w_state_nxt = ST_TRAIL;
        else                                   w_state_nxt = ST_SHIFT;
      end
      ST_TRAIL: if (w_wait_end) w_state_nxt = ST_DONE; else w_state_nxt = ST_TRAIL;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // state register and datapath; MOSI is the tx shift register MSB
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= '0;
      r_wait_cnt <= '0;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
      r_ss       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == ST_TRAIL) && w_wait_end;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_tx_sh    <= bus.tx_data;
            r_rx_sh    <= '0;
            r_bit_cnt  <= '0;
            r_wait_cnt <= '0;
            r_ss       <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        ST_LEAD: begin
          r_wait_cnt <= w_wait_end ? '0 : r_wait_cnt + DIV_CNT_W'(1);
        end
        ST_SHIFT: begin
          if (w_rise) r_bit_cnt <= r_bit_cnt + BIT_W'(1);
          if (w_fall) begin
            r_tx_sh <= {r_tx_sh[DATA_W-2:0], 1'b0};
            r_rx_sh <= {r_rx_sh[DATA_W-2:0], bus.SPI_MISO};
          end
        end
        ST_TRAIL: begin
          r_wait_cnt <= w_wait_end ? '0 : r_wait_cnt + DIV_CNT_W'(1);
          if (w_wait_end) r_rx_data <= r_rx_sh;
        end
        ST_DONE: begin
          r_ss   <= 1'b0;
          r_busy <= 1'b0;
        end
        default: begin
          r_ss   <= 1'b0;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.SPI_SCK  = w_sck;
  assign bus.SPI_MOSI = r_tx_sh[DATA_W-1];
  assign bus.SPI_SS   = r_ss;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.rx_data  = r_rx_data;

endmodule
